// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT front-end loader.
// Values mirror the fft_top defaults (16-bit data, 4 banks x 512 words).
package fft_pkg;

    localparam int FFT_DATA_W    = 16;
    localparam int FFT_ADDR_W    = 9;
    localparam int FFT_BANKS     = 4;
    localparam int FFT_FRAME_LEN = FFT_BANKS << FFT_ADDR_W;
    localparam int FFT_CNT_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LAUNCH,
        S_WAIT_LO,
        S_WAIT_HI
    } fsm_state_t;

    typedef enum logic {
        CNT_WRAP,
        CNT_SAT
    } cnt_mode_t;

    function automatic logic [FFT_CNT_W-1:0] cnt_next(
        input logic [FFT_CNT_W-1:0] c,
        input cnt_mode_t            m
    );
        if (m == CNT_SAT && (&c))
            return c;
        return c + 1'b1;
    endfunction

endpackage

// File: rtl/fft_adc_loader_if.sv
// ADC sample stream: valid/ready handshake into the loader.
// Member names follow the loader's view (i = into loader, o = out of it).
interface fft_adc_loader_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] iSAMPLE;
    logic              iVALID;
    logic              oREADY;

    modport master (
        output iSAMPLE,
        output iVALID,
        input  oREADY
    );

    modport slave (
        input  iSAMPLE,
        input  iVALID,
        output oREADY
    );
endinterface

// File: rtl/fft_sat_cnt.sv
// 16-bit event counter; MODE selects saturate-at-max or wrap.
// Clears only on reset.
module fft_sat_cnt
    import fft_pkg::*;
#(
    parameter cnt_mode_t MODE = CNT_WRAP
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_inc,
    output logic [FFT_CNT_W-1:0] o_cnt
);

    logic [FFT_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= cnt_next(r_cnt, MODE);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fft_adc_loader.sv
// Streams ADC samples into the four fft_top input banks and
// launches the FFT once a full frame has been written.
module fft_adc_loader
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int ADDR_W = FFT_ADDR_W,
    parameter int BANKS  = FFT_BANKS
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iEN,
    fft_adc_loader_if.slave      s_adc,
    output logic [DATA_W-1:0]    oDATA,
    output logic [ADDR_W-1:0]    oADDR_WR_0,
    output logic [ADDR_W-1:0]    oADDR_WR_1,
    output logic [ADDR_W-1:0]    oADDR_WR_2,
    output logic [ADDR_W-1:0]    oADDR_WR_3,
    output logic                 oWE_0,
    output logic                 oWE_1,
    output logic                 oWE_2,
    output logic                 oWE_3,
    output logic                 oSTART,
    input  logic                 iFFT_RDY,
    output logic                 oBUSY,
    output logic [FFT_CNT_W-1:0] oDROP_CNT,
    output logic [FFT_CNT_W-1:0] oFRAME_CNT
);

    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    fsm_state_t        r_state;
    logic [ADDR_W-1:0] r_word;
    logic [ADDR_W-1:0] r_addr;
    logic [BANK_W-1:0] r_bank;
    logic [DATA_W-1:0] r_data;
    logic [BANKS-1:0]  r_we;
    logic              r_start;

    logic w_ready;
    logic w_accept;
    logic w_last;
    logic w_drop;
    logic w_launch;

    // Ready depends only on state and arm level, never on valid.
    assign w_ready  = (r_state == S_FILL) && iEN;
    assign w_accept = w_ready && s_adc.iVALID;
    assign w_last   = (&r_word) && (r_bank == BANK_W'(BANKS - 1));
    assign w_drop   = s_adc.iVALID && !w_ready;
    assign w_launch = (r_state == S_LAUNCH);

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_bank  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= '0;
            r_start <= 1'b0;
        end else begin
            r_we    <= '0;
            r_start <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (iEN) begin
                        r_state <= S_FILL;
                        r_word  <= '0;
                        r_bank  <= '0;
                    end
                end
                S_FILL: begin
                    if (!iEN) begin
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        r_data <= s_adc.iSAMPLE;
                        r_addr <= r_word;
                        r_we   <= BANKS'(1) << r_bank;
                        r_word <= r_word + 1'b1;
                        if (&r_word)
                            r_bank <= r_bank + 1'b1;
                        if (w_last)
                            r_state <= S_LAUNCH;
                    end
                end
                // Launch one cycle after the final write lands.
                S_LAUNCH: begin
                    r_start <= 1'b1;
                    r_state <= S_WAIT_LO;
                end
                // Ignore a ready still high from the previous frame.
                S_WAIT_LO: begin
                    if (!iFFT_RDY)
                        r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (iFFT_RDY) begin
                        if (iEN) begin
                            r_state <= S_FILL;
                            r_word  <= '0;
                            r_bank  <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    fft_sat_cnt #(.MODE(CNT_SAT)) u_drop_cnt (
        .i_clk   (iCLK),
        .i_rst_n (iRESET),
        .i_inc   (w_drop),
        .o_cnt   (oDROP_CNT)
    );

    fft_sat_cnt #(.MODE(CNT_WRAP)) u_frame_cnt (
        .i_clk   (iCLK),
        .i_rst_n (iRESET),
        .i_inc   (w_launch),
        .o_cnt   (oFRAME_CNT)
    );

    assign s_adc.oREADY = w_ready;
    assign oBUSY        = (r_state != S_IDLE);
    assign oSTART       = r_start;
    assign oDATA        = r_data;
    assign oADDR_WR_0   = r_addr;
    assign oADDR_WR_1   = r_addr;
    assign oADDR_WR_2   = r_addr;
    assign oADDR_WR_3   = r_addr;
    assign oWE_0        = r_we[0];
    assign oWE_1        = r_we[1];
    assign oWE_2        = r_we[2];
    assign oWE_3        = r_we[3];

endmodule
